// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready request port to APB SETUP/ACCESS master with local decode check and wait-state timeout
//   clk, rst                               clock, async active-high reset
//   req_valid/ready/we/addr/wdata          core-side request
//   rsp_valid/ready/rdata/err              core-side response
//   paddr/pwrite/psel/penable/pwdata       APB request to interconnect
//   pready/prdata/pslverr                  APB completion from interconnect
//   err_cnt                                saturating count of error responses
module apb_master_bridge #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [19:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [19:0] paddr,
    output logic        pwrite,
    output logic        psel,
    output logic        penable,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic [31:0] prdata,
    input  logic        pslverr,
    output logic [7:0]  err_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t        r_state, w_next;
    logic          r_we, r_err;
    logic [19:0]   r_addr;
    logic [31:0]   r_wdata, r_rdata;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_err_cnt;
    logic          w_bad, w_tout, w_apb;
    // ports 0 and 7 are unmapped; only word-aligned accesses are legal
    assign w_bad  = (req_addr[15:13] == 3'b000) || (req_addr[15:13] == 3'b111) || (req_addr[1:0] != 2'b00);
    // fires on the ACCESS cycle that would be the TIMEOUT_CYCLES-th with pready low
    assign w_tout = (r_tcnt + TW'(1)) == TW'(TIMEOUT_CYCLES);
    assign w_apb  = (r_state == SETUP) || (r_state == ACCESS);
    // address forced to 0 outside a transfer so the interconnect decodes no port
    assign paddr     = w_apb ? r_addr : 20'h0;
    assign pwrite    = w_apb & r_we;
    assign pwdata    = w_apb ? r_wdata : 32'h0;
    assign psel      = w_apb;
    assign penable   = r_state == ACCESS;
    assign req_ready = r_state == IDLE;
    assign rsp_valid = r_state == RESP;
    assign rsp_rdata = rsp_valid ? r_rdata : 32'h0;
    assign rsp_err   = rsp_valid & r_err;
    assign err_cnt   = r_err_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (req_valid) w_next = w_bad ? RESP : SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (pready || w_tout) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_addr    <= 20'h0;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_err     <= 1'b0;
            r_tcnt    <= '0;
            r_err_cnt <= 8'h0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_rdata <= 32'h0;
                r_err   <= w_bad;
            end
            if (r_state == SETUP) r_tcnt <= '0;
            if (r_state == ACCESS) begin
                if (pready) begin
                    r_rdata <= r_we ? 32'h0 : prdata;
                    r_err   <= pslverr;
                end else begin
                    r_tcnt <= r_tcnt + TW'(1);
                    if (w_tout) begin
                        r_rdata <= 32'h0;
                        r_err   <= 1'b1;
                    end
                end
            end
            if (r_state == RESP && rsp_ready && r_err && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end
endmodule
